// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, handshakes with program memory,
// feeds one word per cycle to decode with a one-word skid buffer and
// flushes to NOP on redirect.
module inst_fetch #(
  parameter int unsigned PC_W     = 14,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instR,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc_out
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [PC_W-1:0]     r_pc, w_pc;
  logic [PC_W-1:0]     r_pm_addr, w_pm_addr;
  logic                r_pm_req, w_pm_req;
  logic [DATA_W-1:0]   r_inst, w_inst;
  logic                r_valid, w_valid;
  logic [PC_W-1:0]     r_pc_out, w_pc_out;
  logic [DATA_W-1:0]   r_skid_data, w_skid_data;
  logic [PC_W-1:0]     r_skid_pc, w_skid_pc;
  logic                w_out_free;

  // Decode can take a new word when the current one is a bubble or is being consumed.
  assign w_out_free = !r_valid || !stall;

  // Next-state and next-output computation; redirect overrides everything else.
  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_pm_addr   = r_pm_addr;
    w_inst      = r_inst;
    w_valid     = r_valid;
    w_pc_out    = r_pc_out;
    w_skid_data = r_skid_data;
    w_skid_pc   = r_skid_pc;

    case (r_state)
      S_IDLE: begin
        w_state   = S_REQ;
        w_pm_addr = r_pc;
      end
      S_REQ: begin
        if (pm_ack) begin
          w_pc = r_pc + PC_W'(1);
          if (w_out_free) begin
            w_inst    = pm_data;
            w_pc_out  = r_pm_addr;
            w_valid   = 1'b1;
            w_pm_addr = r_pc + PC_W'(1);
          end else begin
            w_skid_data = pm_data;
            w_skid_pc   = r_pm_addr;
            w_state     = S_FULL;
          end
        end else if (w_out_free) begin
          w_inst  = NOP_WORD;
          w_valid = 1'b0;
        end
      end
      S_FULL: begin
        if (!stall) begin
          w_inst    = r_skid_data;
          w_pc_out  = r_skid_pc;
          w_valid   = 1'b1;
          w_pm_addr = r_pc;
          w_state   = S_REQ;
        end
      end
      S_DROP: begin
        // Stale fetch must still complete; its data is thrown away.
        if (pm_ack) begin
          w_pm_addr = r_pc;
          w_state   = S_REQ;
        end
        if (w_out_free) begin
          w_inst  = NOP_WORD;
          w_valid = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (redirect_valid) begin
      w_inst      = NOP_WORD;
      w_valid     = 1'b0;
      w_skid_data = NOP_WORD;
      w_skid_pc   = '0;
      w_pc        = redirect_pc;
      if (((r_state == S_REQ) || (r_state == S_DROP)) && !pm_ack) begin
        w_state = S_DROP;
      end else begin
        w_pm_addr = redirect_pc;
        w_state   = S_REQ;
      end
    end

    w_pm_req = (w_state == S_REQ) || (w_state == S_DROP);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_pm_addr   <= '0;
      r_pm_req    <= 1'b0;
      r_inst      <= NOP_WORD;
      r_valid     <= 1'b0;
      r_pc_out    <= '0;
      r_skid_data <= NOP_WORD;
      r_skid_pc   <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_pm_addr   <= w_pm_addr;
      r_pm_req    <= w_pm_req;
      r_inst      <= w_inst;
      r_valid     <= w_valid;
      r_pc_out    <= w_pc_out;
      r_skid_data <= w_skid_data;
      r_skid_pc   <= w_skid_pc;
    end
  end

  assign pm_req     = r_pm_req;
  assign pm_addr    = r_pm_addr;
  assign instR      = r_inst;
  assign inst_valid = r_valid;
  assign pc_out     = r_pc_out;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory responder with configurable wait states,
// program-order scoreboard, directed scenarios then random stall/redirect.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [13:0] redirect_pc = '0;
  logic        pm_req;
  logic [13:0] pm_addr;
  logic        pm_ack = 1'b0;
  logic [15:0] pm_data = '0;
  logic [15:0] instR;
  logic        inst_valid;
  logic [13:0] pc_out;

  inst_fetch #(.PC_W(14), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_data(pm_data),
    .instR(instR), .inst_valid(inst_valid), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] exp_tail;
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;
  int          wait_mode = 0;  // <0: random 0..3 wait states per fetch

  function automatic logic [15:0] mem_fn(input logic [13:0] a);
    return 16'h0C00 + 16'(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Program order: words are expected at consecutive addresses from the last target.
  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{a: exp_tail, d: mem_fn(exp_tail)});
      exp_tail = exp_tail + 14'd1;
    end
  endfunction

  function automatic void restart_stream(input logic [13:0] a);
    exp_q.delete();
    exp_tail = a;
    refill();
  endfunction

  function automatic int pick_wait();
    if (wait_mode < 0) return int'($urandom_range(0, 3));
    return wait_mode;
  endfunction

  // Program memory model: acks after a per-fetch number of wait cycles.
  initial begin
    int cnt = 0;
    int cur_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        cur_wait = pick_wait();
        pm_ack = 1'b0;
      end else if (pm_req) begin
        if (cnt >= cur_wait) begin
          pm_ack = 1'b1;
          pm_data = mem_fn(pm_addr);
          cnt = 0;
          cur_wait = pick_wait();
        end else begin
          pm_ack = 1'b0;
          pm_data = 16'($urandom);
          cnt++;
        end
      end else begin
        pm_ack = 1'b0;
        pm_data = 16'($urandom);
      end
    end
  end

  // Monitor: protocol and program-order checks each cycle.
  initial begin
    logic        p_valid = 1'b0;
    logic        p_req = 1'b0;
    logic [15:0] p_inst = '0;
    logic [13:0] p_pc = '0;
    logic [13:0] p_addr = '0;
    logic        a_ack, a_redir, a_stall, a_rst;
    exp_t        e;
    forever begin
      @(posedge clk);
      a_ack = pm_ack; a_redir = redirect_valid; a_stall = stall; a_rst = rst;
      #1;
      if (rst || a_rst) begin
        p_valid = 1'b0;
        p_req = 1'b0;
        continue;
      end
      if (p_req && !a_ack) begin
        check("pm_req_hold", 32'(pm_req), 32'd1);
        check("pm_addr_hold", 32'(pm_addr), 32'(p_addr));
      end
      if (a_redir) begin
        check("redir_valid", 32'(inst_valid), 32'd0);
        check("redir_nop", 32'(instR), 32'h0000);
      end else if (p_valid && a_stall) begin
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_inst", 32'(instR), 32'(p_inst));
        check("stall_pc", 32'(pc_out), 32'(p_pc));
      end else if (inst_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 32'(pc_out), 32'(e.a));
          check("sb_inst", 32'(instR), 32'(e.d));
          delivered++;
        end
      end else begin
        check("bubble_nop", 32'(instR), 32'h0000);
      end
      p_valid = inst_valid; p_req = pm_req; p_inst = instR; p_pc = pc_out; p_addr = pm_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
    refill();
  endtask

  task automatic do_redirect(input logic [13:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    restart_stream(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  // Stimulus: directed scenarios then random stall/redirect with random wait states.
  initial begin
    bit found;
    restart_stream(14'd0);
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_inst", 32'(instR), 32'h0000);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(pm_req), 32'd0);
    check("rst_addr", 32'(pm_addr), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    rst = 1'b0;
    tick();
    check("first_req", 32'(pm_req), 32'd1);
    check("first_addr", 32'(pm_addr), 32'd0);
    check("first_valid", 32'(inst_valid), 32'd0);
    tick();
    check("first_inst", 32'(instR), 32'h0C00);
    check("first_vld1", 32'(inst_valid), 32'd1);
    tick(); tick();
    check("pre_stall", 32'(instR), 32'h0C02);

    // Stall three cycles with 0C02 held.
    stall = 1'b1;
    tick();
    check("full_no_req", 32'(pm_req), 32'd0);
    tick(); tick();
    check("stall_hold", 32'(instR), 32'h0C02);
    stall = 1'b0;
    tick();
    check("skid_out", 32'(instR), 32'h0C03);
    check("skid_pc", 32'(pc_out), 32'd3);
    tick();
    check("post_skid", 32'(instR), 32'h0C04);

    // Redirect with zero-wait memory.
    do_redirect(14'h0100);
    check("rd_bubble", 32'(inst_valid), 32'd0);
    tick();
    check("rd_inst", 32'(instR), 32'(mem_fn(14'h0100)));
    check("rd_pc", 32'(pc_out), 32'h0100);

    // Address wrap.
    do_redirect(14'h3FFE);
    tick(); check("wrap0", 32'(pc_out), 32'h3FFE);
    tick(); check("wrap1", 32'(pc_out), 32'h3FFF);
    tick(); check("wrap2", 32'(pc_out), 32'h0000);
    tick(); check("wrap3", 32'(pc_out), 32'h0001);

    // Two-wait memory, redirect while fetch of address 5 is outstanding.
    wait_mode = 2;
    do_redirect(14'd0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (pm_req && pm_addr == 14'd5) found = 1; else tick();
    end
    check("reach_addr5", 32'(found), 32'd1);
    do_redirect(14'h0200);
    check("drop_addr", 32'(pm_addr), 32'd5);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pm_addr == 14'h0200) found = 1; else tick();
    end
    check("reach_200", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid) found = 1; else tick();
    end
    check("valid_200", 32'(found), 32'd1);
    check("inst_200", 32'(instR), 32'(mem_fn(14'h0200)));

    // Asynchronous reset while holding a skid word.
    wait_mode = 0;
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    check("full_state", 32'(pm_req), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_inst", 32'(instR), 32'h0000);
    check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_pc", 32'(pc_out), 32'd0);
    check("arst_addr", 32'(pm_addr), 32'd0);
    tick();
    restart_stream(14'd0);
    stall = 1'b0;
    rst = 1'b0;
    tick();
    check("rerun_addr", 32'(pm_addr), 32'd0);
    check("rerun_req", 32'(pm_req), 32'd1);
    tick();
    check("rerun_inst", 32'(instR), 32'h0C00);

    // Random phase.
    wait_mode = -1;
    for (int i = 0; i < 2000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) do_redirect(14'($urandom));
      else tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("progress", 32'(delivered > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
